// File: rtl/dsp_mult_share_pkg.sv
// Shared types and constants for the multiplier-sharing controller.
// Operator codes follow the riscv_defines MUL_* encoding.
package dsp_mult_share_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [2:0] MUL_MAC32    = 3'b000;
  localparam logic [2:0] MULT_IDLE_OP = MUL_MAC32;

  typedef struct packed {
    logic [2:0]        operator;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] op_c;
    logic [1:0]        dot_signed;
  } mult_req_t;

  // Operand pattern driven to the multiplier on idle cycles (result 0, no toggling).
  localparam mult_req_t MULT_REQ_IDLE = '{operator: MULT_IDLE_OP, default: '0};

endpackage

// File: rtl/dsp_mult_rr_arb.sv
// Round-robin arbiter: one-hot grant plus winner ID, pointer advances past each winner.
module dsp_mult_rr_arb #(
  parameter int unsigned NB_CORES = 4,
  parameter int unsigned ID_WIDTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NB_CORES-1:0] req_i,
  input  logic                en_i,
  output logic [NB_CORES-1:0] gnt_o,
  output logic [ID_WIDTH-1:0] id_o,
  output logic                valid_o
);

  localparam int unsigned SW = ID_WIDTH + 1;
  localparam logic [SW-1:0] NB_W = SW'(NB_CORES);

  logic [ID_WIDTH-1:0] ptr_q, ptr_d;
  logic [SW-1:0]       cand;
  logic [SW-1:0]       nxt;

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  // Search requesters starting at the pointer, wrapping modulo NB_CORES.
  always_comb begin
    gnt_o   = '0;
    id_o    = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned off = 0; off < NB_CORES; off++) begin
      cand = {1'b0, ptr_q} + SW'(off);
      if (cand >= NB_W) cand = cand - NB_W;
      if (!valid_o && req_i[cand[ID_WIDTH-1:0]]) begin
        valid_o = 1'b1;
        id_o    = cand[ID_WIDTH-1:0];
      end
    end
    if (valid_o) gnt_o[id_o] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    nxt   = {1'b0, id_o} + SW'(1);
    if (en_i && valid_o) ptr_d = (nxt >= NB_W) ? '0 : nxt[ID_WIDTH-1:0];
  end

endmodule

// File: rtl/dsp_mult_share_ctrl.sv
// Shares one combinational dsp_mult among NB_CORES cores: round-robin grant,
// registered issue stage, registered writeback, 2-cycle grant-to-result latency.
module dsp_mult_share_ctrl
  import dsp_mult_share_pkg::*;
#(
  parameter int unsigned NB_CORES = 4,
  parameter int unsigned ID_WIDTH = $clog2(NB_CORES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NB_CORES-1:0]        core_req_i,
  output logic [NB_CORES-1:0]        core_gnt_o,
  input  logic [NB_CORES-1:0][2:0]   core_operator_i,
  input  logic [NB_CORES-1:0][31:0]  core_op_a_i,
  input  logic [NB_CORES-1:0][31:0]  core_op_b_i,
  input  logic [NB_CORES-1:0][31:0]  core_op_c_i,
  input  logic [NB_CORES-1:0][1:0]   core_dot_signed_i,
  output logic [NB_CORES-1:0]        core_rvalid_o,
  output logic [31:0]                core_result_o,
  output logic [2:0]                 mult_operator_o,
  output logic [31:0]                mult_op_a_o,
  output logic [31:0]                mult_op_b_o,
  output logic [31:0]                mult_op_c_o,
  output logic [1:0]                 mult_dot_signed_o,
  input  logic [31:0]                mult_result_i
);

  logic [NB_CORES-1:0] arb_gnt;
  logic [ID_WIDTH-1:0] arb_id;
  logic                arb_valid;

  mult_req_t           s1_req_q, s1_req_d;
  logic                s1_valid_q, s1_valid_d;
  logic [ID_WIDTH-1:0] s1_id_q, s1_id_d;
  logic [NB_CORES-1:0] rvalid_q, rvalid_d;
  logic [31:0]         res_q, res_d;

  dsp_mult_rr_arb #(
    .NB_CORES (NB_CORES),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_i   (core_req_i),
    .en_i    (~rst),
    .gnt_o   (arb_gnt),
    .id_o    (arb_id),
    .valid_o (arb_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_req_q   <= MULT_REQ_IDLE;
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      rvalid_q   <= '0;
      res_q      <= '0;
    end else begin
      s1_req_q   <= s1_req_d;
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      rvalid_q   <= rvalid_d;
      res_q      <= res_d;
    end
  end

  // Idle cycles load the idle pattern so the multiplier inputs come straight from flops.
  always_comb begin
    s1_valid_d = arb_valid;
    s1_id_d    = arb_id;
    s1_req_d   = MULT_REQ_IDLE;
    rvalid_d   = '0;
    res_d      = res_q;
    if (arb_valid) begin
      s1_req_d = '{operator:   core_operator_i[arb_id],
                   op_a:       core_op_a_i[arb_id],
                   op_b:       core_op_b_i[arb_id],
                   op_c:       core_op_c_i[arb_id],
                   dot_signed: core_dot_signed_i[arb_id]};
    end
    if (s1_valid_q) begin
      rvalid_d[s1_id_q] = 1'b1;
      res_d             = mult_result_i;
    end
  end

  // Grants and pulses are suppressed while reset is held so in-flight work is dropped.
  assign core_gnt_o        = rst ? '0 : arb_gnt;
  assign core_rvalid_o     = rst ? '0 : rvalid_q;
  assign core_result_o     = res_q;

  assign mult_operator_o   = s1_req_q.operator;
  assign mult_op_a_o       = s1_req_q.op_a;
  assign mult_op_b_o       = s1_req_q.op_b;
  assign mult_op_c_o       = s1_req_q.op_c;
  assign mult_dot_signed_o = s1_req_q.dot_signed;

endmodule

// File: tb/tb_dsp_mult_share_ctrl.sv
// Scoreboard bench for dsp_mult_share_ctrl with a behavioural dsp_mult model.
module tb_dsp_mult_share_ctrl;

  localparam int NB = 4;
  localparam logic [2:0] OP_MAC32 = 3'b000;
  localparam logic [2:0] OP_DOT8  = 3'b100;
  localparam logic [2:0] OP_DOT16 = 3'b101;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NB-1:0]        core_req;
  logic [NB-1:0]        core_gnt;
  logic [NB-1:0][2:0]   core_operator;
  logic [NB-1:0][31:0]  core_op_a, core_op_b, core_op_c;
  logic [NB-1:0][1:0]   core_dot_signed;
  logic [NB-1:0]        core_rvalid;
  logic [31:0]          core_result;
  logic [2:0]           mult_operator;
  logic [31:0]          mult_op_a, mult_op_b, mult_op_c;
  logic [1:0]           mult_dot_signed;
  logic [31:0]          mult_result;

  int checks = 0;
  int errors = 0;
  longint cyc = 0;

  typedef struct {
    int          id;
    logic [31:0] res;
    longint      due;
  } exp_t;
  exp_t exp_q[$];

  dsp_mult_share_ctrl #(.NB_CORES(NB)) dut (
    .clk               (clk),
    .rst               (rst),
    .core_req_i        (core_req),
    .core_gnt_o        (core_gnt),
    .core_operator_i   (core_operator),
    .core_op_a_i       (core_op_a),
    .core_op_b_i       (core_op_b),
    .core_op_c_i       (core_op_c),
    .core_dot_signed_i (core_dot_signed),
    .core_rvalid_o     (core_rvalid),
    .core_result_o     (core_result),
    .mult_operator_o   (mult_operator),
    .mult_op_a_o       (mult_op_a),
    .mult_op_b_o       (mult_op_b),
    .mult_op_c_o       (mult_op_c),
    .mult_dot_signed_o (mult_dot_signed),
    .mult_result_i     (mult_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Dot-product reference: sum of lane products plus C; non-dot operators yield 0.
  function automatic logic [31:0] ref_mult(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] c,
                                           input logic [1:0] s);
    longint acc, ea, eb;
    acc = longint'(c);
    if (op == OP_DOT8) begin
      for (int i = 0; i < 4; i++) begin
        ea = s[1] ? longint'($signed(a[8*i +: 8])) : longint'(a[8*i +: 8]);
        eb = s[0] ? longint'($signed(b[8*i +: 8])) : longint'(b[8*i +: 8]);
        acc += ea * eb;
      end
    end else if (op == OP_DOT16) begin
      for (int i = 0; i < 2; i++) begin
        ea = s[1] ? longint'($signed(a[16*i +: 16])) : longint'(a[16*i +: 16]);
        eb = s[0] ? longint'($signed(b[16*i +: 16])) : longint'(b[16*i +: 16]);
        acc += ea * eb;
      end
    end else begin
      return 32'h0;
    end
    return acc[31:0];
  endfunction

  assign mult_result = ref_mult(mult_operator, mult_op_a, mult_op_b, mult_op_c, mult_dot_signed);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor / reference model state
  int          m_ptr = 0;
  int          win;
  logic        prev_v = 1'b0;
  logic [2:0]  prev_op;
  logic [31:0] prev_a, prev_b, prev_c;
  logic [1:0]  prev_s;
  logic [31:0] last_res = '0;
  logic [NB-1:0] eg, ev;
  exp_t        e;

  always @(negedge clk) begin
    if (rst) begin
      chk("gnt_in_rst", 64'(core_gnt), 64'(0));
      chk("rvalid_in_rst", 64'(core_rvalid), 64'(0));
      exp_q.delete();
      m_ptr    = 0;
      prev_v   = 1'b0;
      last_res = '0;
    end else begin
      if (prev_v) begin
        chk("mult_op", 64'(mult_operator), 64'(prev_op));
        chk("mult_a", 64'(mult_op_a), 64'(prev_a));
        chk("mult_b", 64'(mult_op_b), 64'(prev_b));
        chk("mult_c", 64'(mult_op_c), 64'(prev_c));
        chk("mult_sgn", 64'(mult_dot_signed), 64'(prev_s));
      end else begin
        chk("mult_idle", {mult_operator, mult_op_a, mult_op_b[28:0]},
            {OP_MAC32, 32'h0, 29'h0});
        chk("mult_idle_bc", {mult_op_b, mult_op_c[29:0], mult_dot_signed}, 64'(0));
      end

      if (core_rvalid != '0) begin
        if (exp_q.size() == 0) begin
          chk("rvalid_unexpected", 64'(core_rvalid), 64'(0));
        end else begin
          e  = exp_q.pop_front();
          ev = '0;
          ev[e.id] = 1'b1;
          chk("rvalid_vec", 64'(core_rvalid), 64'(ev));
          chk("result", 64'(core_result), 64'(e.res));
          chk("latency", 64'(cyc), 64'(e.due));
          last_res = e.res;
        end
      end else begin
        if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          e  = exp_q.pop_front();
          ev = '0;
          ev[e.id] = 1'b1;
          chk("rvalid_missing", 64'(core_rvalid), 64'(ev));
        end
        chk("result_hold", 64'(core_result), 64'(last_res));
      end

      win = -1;
      for (int k = 0; k < NB; k++) begin
        if (win < 0 && core_req[(m_ptr + k) % NB]) win = (m_ptr + k) % NB;
      end
      eg = '0;
      if (win >= 0) eg[win] = 1'b1;
      chk("gnt", 64'(core_gnt), 64'(eg));
      if (win >= 0) begin
        e.id  = win;
        e.res = ref_mult(core_operator[win], core_op_a[win], core_op_b[win],
                         core_op_c[win], core_dot_signed[win]);
        e.due = cyc + 2;
        exp_q.push_back(e);
        m_ptr   = (win + 1) % NB;
        prev_v  = 1'b1;
        prev_op = core_operator[win];
        prev_a  = core_op_a[win];
        prev_b  = core_op_b[win];
        prev_c  = core_op_c[win];
        prev_s  = core_dot_signed[win];
      end else begin
        prev_v = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int i, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] c, input logic [1:0] s);
    core_operator[i]   = op;
    core_op_a[i]       = a;
    core_op_b[i]       = b;
    core_op_c[i]       = c;
    core_dot_signed[i] = s;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    core_req        = '0;
    core_operator   = '0;
    core_op_a       = '0;
    core_op_b       = '0;
    core_op_c       = '0;
    core_dot_signed = '0;
    repeat (3) step();
    rst = 1'b0;
    #1;
    chk("reset_result", 64'(core_result), 64'(0));
    chk("reset_rvalid", 64'(core_rvalid), 64'(0));

    // Core 1 DOT8
    set_core(1, OP_DOT8, 32'h01020304, 32'h01010101, 32'h0, 2'b11);
    core_req = 4'b0010;
    #1 chk("t1_gnt", 64'(core_gnt), 64'(4'b0010));
    step(); core_req = '0;
    step();
    #1 chk("t1_rvalid", 64'(core_rvalid), 64'(4'b0010));
    chk("t1_result", 64'(core_result), 64'(32'h0000000A));

    // Core 0 DOT16 with accumulator
    step();
    set_core(0, OP_DOT16, 32'hFFFF0002, 32'h00030004, 32'd10, 2'b11);
    core_req = 4'b0001;
    step(); core_req = '0;
    step();
    #1 chk("t2_rvalid", 64'(core_rvalid), 64'(4'b0001));
    chk("t2_result", 64'(core_result), 64'(32'h0000000F));
    repeat (2) step();

    // All cores continuously from pointer 0
    reset_dut();
    for (int i = 0; i < NB; i++)
      set_core(i, OP_DOT8, $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)));
    core_req = 4'b1111;
    repeat (8) step();
    core_req = '0;
    repeat (3) step();

    // Cores 2 and 3; core 2 drops after its grant
    reset_dut();
    core_req = 4'b1100;
    #1 chk("t4_gnt2", 64'(core_gnt), 64'(4'b0100));
    step(); core_req = 4'b1000;
    repeat (4) step();
    core_req = '0;
    repeat (3) step();

    // Back-to-back grants then reset: both results discarded
    core_req = 4'b0011;
    step(); step();
    core_req = '0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    #1 chk("t5_rvalid", 64'(core_rvalid), 64'(0));
    chk("t5_result", 64'(core_result), 64'(0));
    core_req = 4'b1000;
    #1 chk("t5_gnt3", 64'(core_gnt), 64'(4'b1000));
    step(); core_req = '0;
    repeat (3) step();

    // Non-dot operator returns 0
    set_core(2, OP_MAC32, 32'd5, 32'd6, 32'd0, 2'b00);
    core_req = 4'b0100;
    step(); core_req = '0;
    step();
    #1 chk("t6_rvalid", 64'(core_rvalid), 64'(4'b0100));
    chk("t6_result", 64'(core_result), 64'(0));
    repeat (2) step();

    // Randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 59) == 0);
      core_req = NB'($urandom);
      for (int i = 0; i < NB; i++) begin
        case ($urandom_range(0, 3))
          0:       set_core(i, OP_DOT8, $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)));
          1:       set_core(i, OP_DOT16, $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)));
          default: set_core(i, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                            2'($urandom_range(0, 3)));
        endcase
      end
      step();
    end
    rst      = 1'b0;
    core_req = '0;
    repeat (4) step();
    chk("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
